// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary payload types and widths.
// Sizes the per-stage pipe_stage_skid registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  // Control half: zeroed whenever the stage carries a bubble.
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [1:0]  spare;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } data_t;

  typedef struct packed {
    ctrl_t ctrl;
    data_t data;
  } ex_mem_t;

  typedef struct packed {
    ctrl_t ctrl;
    data_t data;
  } mem_wb_t;

  localparam int MEM_WB_CTRL_W = $bits(ctrl_t);
  localparam int MEM_WB_DATA_W = $bits(data_t);

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: valid flag plus control and data registers.
// Clear drops valid and control but keeps data; a bubble load does the same.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              next_valid,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DATA_W-1:0] next_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= next_valid;
      if (next_valid) begin
        ctrl <= next_ctrl;
        data <= next_data;
      end else begin
        ctrl <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready handshake, stall, flush
// and an optional one-entry skid buffer that registers o_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  // Handshake: a beat moves on an edge where valid & ready are both high on that
  // side; a stalled producer must hold valid and payload until it is accepted.
  logic              in_beat;
  logic              out_beat;
  logic              m_take;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              m_next_valid;
  logic [CTRL_W-1:0] m_next_ctrl;
  logic [DATA_W-1:0] m_next_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              s_load;
  logic              s_next_valid;
  logic [1:0]        count_q;

  assign in_beat  = i_valid & o_ready;
  assign out_beat = m_valid & i_ready;
  assign m_take   = ~m_valid | i_ready;

  // The skid entry is older than anything arriving now, so it refills M first.
  always_comb begin
    m_next_valid = in_beat;
    m_next_ctrl  = i_ctrl;
    m_next_data  = i_data;
    if (s_valid) begin
      m_next_valid = 1'b1;
      m_next_ctrl  = s_ctrl;
      m_next_data  = s_data;
    end
    s_load       = m_take ? s_valid : in_beat;
    s_next_valid = in_beat;
  end

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (m_take),
    .clear     (i_flush),
    .next_valid(m_next_valid),
    .next_ctrl (m_next_ctrl),
    .next_data (m_next_data),
    .valid     (m_valid),
    .ctrl      (m_ctrl),
    .data      (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      pipe_slot #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) u_skid (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (s_load),
        .clear     (i_flush),
        .next_valid(s_next_valid),
        .next_ctrl (i_ctrl),
        .next_data (i_data),
        .valid     (s_valid),
        .ctrl      (s_ctrl),
        .data      (s_data)
      );

      // Mirrors ~s_valid one edge late-free: updated together with the skid slot.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ready_q <= 1'b1;
        end else if (i_flush) begin
          ready_q <= 1'b1;
        end else if (s_load) begin
          ready_q <= ~s_next_valid;
        end
      end

      assign o_ready = ready_q;
    end else begin : g_single
      assign s_valid = 1'b0;
      assign s_ctrl  = '0;
      assign s_data  = '0;
      assign o_ready = i_ready | ~m_valid;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= 2'd0;
    end else if (i_flush) begin
      count_q <= 2'd0;
    end else if (in_beat && !out_beat) begin
      count_q <= count_q + 2'd1;
    end else if (!in_beat && out_beat) begin
      count_q <= count_q - 2'd1;
    end
  end

  assign o_valid = m_valid;
  assign o_ctrl  = m_valid ? m_ctrl : '0;
  assign o_data  = m_data;
  assign o_count = count_q;

`ifndef SYNTHESIS
  a_hold_when_stalled : assert property (
    @(posedge i_clk) disable iff (!i_rst_n || i_flush)
      (i_valid && !o_ready) |=> (!i_valid || ($stable(i_ctrl) && $stable(i_data)))
  ) else $error("upstream changed payload while back-pressured");
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid build (a_*) and single-slot build (b_*)
// share clock and reset; each check is an immediate assertion against hand values.
module tb_pipe_stage_skid;

  localparam int CW = 8;
  localparam int DW = 101;

  localparam logic [DW-1:0] DA  = 101'h1F_0000_0000_0000_0000_0000_00A1;
  localparam logic [DW-1:0] DB  = 101'h0A_5555_0000_0000_0000_0000_00B2;
  localparam logic [DW-1:0] DC  = 101'h00_0000_0000_0000_0000_0000_0CC3;
  localparam logic [DW-1:0] D11 = 101'h00_0000_0000_0000_0000_0000_0011;
  localparam logic [DW-1:0] D22 = 101'h00_0000_0000_0000_0000_0000_0022;
  localparam logic [DW-1:0] D31 = 101'h00_0000_0000_0000_0000_0000_0031;
  localparam logic [DW-1:0] D32 = 101'h00_0000_0000_0000_0000_0000_0032;
  localparam logic [DW-1:0] D33 = 101'h00_0000_0000_0000_0000_0000_0033;

  logic          clk;
  logic          rst_n;

  logic          a_valid, a_flush, a_ready, a_accept, a_out_valid;
  logic [CW-1:0] a_ctrl, a_out_ctrl;
  logic [DW-1:0] a_data, a_out_data;
  logic [1:0]    a_count;

  logic          b_valid, b_flush, b_ready, b_accept, b_out_valid;
  logic [CW-1:0] b_ctrl, b_out_ctrl;
  logic [DW-1:0] b_data, b_out_data;
  logic [1:0]    b_count;

  logic [DW-1:0] seq [5];
  int            checks;
  int            failures;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut_skid (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(a_valid),
    .o_ready(a_accept),
    .i_ctrl (a_ctrl),
    .i_data (a_data),
    .i_flush(a_flush),
    .o_valid(a_out_valid),
    .i_ready(a_ready),
    .o_ctrl (a_out_ctrl),
    .o_data (a_out_data),
    .o_count(a_count)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut_single (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(b_valid),
    .o_ready(b_accept),
    .i_ctrl (b_ctrl),
    .i_data (b_data),
    .i_flush(b_flush),
    .o_valid(b_out_valid),
    .i_ready(b_ready),
    .o_ctrl (b_out_ctrl),
    .o_data (b_out_data),
    .o_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    seq[0] = 101'h0_0000_0000_0000_0000_0000_000A;
    seq[1] = 101'h0_0000_0000_0000_0000_0000_000B;
    seq[2] = 101'h1_0000_0000_0000_0000_0000_000C;
    seq[3] = 101'h0_8000_0000_0000_0000_0000_000D;
    seq[4] = 101'h1F_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    rst_n = 1'b0;
    a_valid = 1'b0; a_ctrl = '0; a_data = '0; a_flush = 1'b0; a_ready = 1'b1;
    b_valid = 1'b0; b_ctrl = '0; b_data = '0; b_flush = 1'b0; b_ready = 1'b1;

    // reset state
    step();
    step();
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_ctrl", a_out_ctrl, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_a_count", a_count, 0);
    check("rst_a_ready", a_accept, 1);
    check("rst_b_ready", b_accept, 1);
    check("rst_b_count", b_count, 0);
    rst_n = 1'b1;

    // skid build: streaming, one beat per cycle, 1 cycle latency
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_ctrl = 8'h81; a_data = seq[i];
      step();
      check("a_stream_valid", a_out_valid, 1);
      check("a_stream_ctrl", a_out_ctrl, 8'h81);
      check("a_stream_data", a_out_data, seq[i]);
      check("a_stream_count", a_count, 1);
      check("a_stream_ready", a_accept, 1);
    end

    // bubbles: control forced low, data held
    a_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("a_bubble_valid", a_out_valid, 0);
      check("a_bubble_ctrl", a_out_ctrl, 0);
      check("a_bubble_data", a_out_data, seq[4]);
      check("a_bubble_count", a_count, 0);
    end

    // stall with skid: A held in M, B absorbed by S
    a_ready = 1'b0; a_valid = 1'b1; a_ctrl = 8'h42; a_data = DA;
    step();
    check("a_stall1_data", a_out_data, DA);
    check("a_stall1_count", a_count, 1);
    check("a_stall1_ready", a_accept, 1);
    a_ctrl = 8'h24; a_data = DB;
    step();
    check("a_stall2_data", a_out_data, DA);
    check("a_stall2_ctrl", a_out_ctrl, 8'h42);
    check("a_stall2_count", a_count, 2);
    check("a_stall2_ready", a_accept, 0);
    a_valid = 1'b0;
    step();
    check("a_stall3_data", a_out_data, DA);
    check("a_stall3_count", a_count, 2);
    check("a_stall3_ready", a_accept, 0);
    a_ready = 1'b1;
    step();
    check("a_release_valid", a_out_valid, 1);
    check("a_release_data", a_out_data, DB);
    check("a_release_ctrl", a_out_ctrl, 8'h24);
    check("a_release_count", a_count, 1);
    check("a_release_ready", a_accept, 1);
    step();
    check("a_drain_valid", a_out_valid, 0);
    check("a_drain_count", a_count, 0);
    check("a_drain_data", a_out_data, DB);

    // flush collision with both slots full
    a_ready = 1'b0; a_valid = 1'b1; a_ctrl = 8'h81; a_data = D11;
    step();
    a_data = D22;
    step();
    check("a_pre_flush_count", a_count, 2);
    check("a_pre_flush_ready", a_accept, 0);
    a_data = DC; a_flush = 1'b1;
    step();
    check("a_flush_valid", a_out_valid, 0);
    check("a_flush_ctrl", a_out_ctrl, 0);
    check("a_flush_count", a_count, 0);
    check("a_flush_ready", a_accept, 1);
    check("a_flush_data", a_out_data, D11);
    a_flush = 1'b0; a_valid = 1'b0; a_ready = 1'b1;
    step();
    check("a_post_flush_valid", a_out_valid, 0);
    check("a_post_flush_count", a_count, 0);
    step();
    check("a_post_flush_valid2", a_out_valid, 0);
    check("a_post_flush_data", a_out_data, D11);

    // reset mid-stream: M, S and an input beat all in flight
    a_ready = 1'b0; a_valid = 1'b1; a_ctrl = 8'h81; a_data = D31;
    step();
    a_data = D32;
    step();
    check("a_inflight_count", a_count, 2);
    a_data = D33;
    #2;
    rst_n = 1'b0;
    #1;
    check("a_midrst_valid", a_out_valid, 0);
    check("a_midrst_ctrl", a_out_ctrl, 0);
    check("a_midrst_count", a_count, 0);
    check("a_midrst_ready", a_accept, 1);
    check("a_midrst_data", a_out_data, 0);
    step();
    check("a_inrst_valid", a_out_valid, 0);
    check("a_inrst_count", a_count, 0);
    rst_n = 1'b1; a_valid = 1'b0; a_ready = 1'b1;
    step();
    check("a_after_rst_valid", a_out_valid, 0);
    check("a_after_rst_count", a_count, 0);

    // single-slot build: streaming
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1; b_ctrl = 8'h81; b_data = seq[4-i];
      step();
      check("b_stream_valid", b_out_valid, 1);
      check("b_stream_ctrl", b_out_ctrl, 8'h81);
      check("b_stream_data", b_out_data, seq[4-i]);
      check("b_stream_count", b_count, 1);
      check("b_stream_ready", b_accept, 1);
    end
    b_valid = 1'b0;
    step();
    check("b_bubble_valid", b_out_valid, 0);
    check("b_bubble_ctrl", b_out_ctrl, 0);
    check("b_bubble_data", b_out_data, seq[0]);
    check("b_bubble_count", b_count, 0);

    // single-slot stall: o_ready follows i_ready in the same cycle
    b_ready = 1'b0; b_valid = 1'b1; b_ctrl = 8'h42; b_data = DA;
    #1;
    check("b_empty_ready", b_accept, 1);
    step();
    check("b_stall_data", b_out_data, DA);
    check("b_stall_count", b_count, 1);
    check("b_stall_ready", b_accept, 0);
    b_ctrl = 8'h24; b_data = DB;
    step();
    check("b_held_data", b_out_data, DA);
    check("b_held_ctrl", b_out_ctrl, 8'h42);
    check("b_held_count", b_count, 1);
    b_ready = 1'b1;
    #1;
    check("b_ready_follow_hi", b_accept, 1);
    step();
    check("b_release_data", b_out_data, DB);
    check("b_release_ctrl", b_out_ctrl, 8'h24);
    check("b_release_count", b_count, 1);
    b_ready = 1'b0;
    #1;
    check("b_ready_follow_lo", b_accept, 0);
    b_valid = 1'b0; b_ready = 1'b1;
    step();
    check("b_drain_valid", b_out_valid, 0);
    check("b_drain_count", b_count, 0);

    // single-slot flush while an input beat would be accepted
    b_ready = 1'b0; b_valid = 1'b1; b_ctrl = 8'h81; b_data = D11;
    step();
    check("b_pre_flush_count", b_count, 1);
    b_ready = 1'b1; b_data = DC; b_flush = 1'b1;
    #1;
    check("b_flush_accept", b_accept, 1);
    step();
    check("b_flush_valid", b_out_valid, 0);
    check("b_flush_ctrl", b_out_ctrl, 0);
    check("b_flush_count", b_count, 0);
    check("b_flush_data", b_out_data, D11);
    b_flush = 1'b0; b_valid = 1'b0;
    step();
    check("b_post_flush_valid", b_out_valid, 0);
    check("b_post_flush_count", b_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
